// File: rtl/cva6_hpdcache_load_tracker.sv
// In-order load return tracker for the HPDcache: tags loads with ring-buffer TIDs,
// absorbs out-of-order cache responses and hands data back in issue order.
module cva6_hpdcache_load_tracker #(
  parameter int unsigned NR_ENTRIES = 8,
  parameter int unsigned ID_W       = $clog2(NR_ENTRIES),
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              ld_req_valid_i,
  output logic              ld_req_ready_o,
  input  logic [ADDR_W-1:0] ld_req_addr_i,
  input  logic [1:0]        ld_req_size_i,
  output logic              cache_req_valid_o,
  input  logic              cache_req_ready_i,
  output logic [ADDR_W-1:0] cache_req_addr_o,
  output logic [1:0]        cache_req_size_o,
  output logic [ID_W-1:0]   cache_req_tid_o,
  input  logic              cache_rsp_valid_i,
  input  logic [ID_W-1:0]   cache_rsp_tid_i,
  input  logic [DATA_W-1:0] cache_rsp_data_i,
  input  logic              cache_rsp_error_i,
  output logic              ld_rsp_valid_o,
  input  logic              ld_rsp_ready_i,
  output logic [DATA_W-1:0] ld_rsp_data_o,
  output logic              ld_rsp_error_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    E_FREE,
    E_PEND,
    E_PEND_K,
    E_DONE,
    E_DONE_K
  } entry_state_e;

  entry_state_e      state_q [NR_ENTRIES];
  entry_state_e      state_d [NR_ENTRIES];
  logic [DATA_W-1:0] data_q  [NR_ENTRIES];
  logic              err_q   [NR_ENTRIES];

  logic [ID_W:0]   head_q, tail_q;
  logic [ID_W-1:0] head_idx, tail_idx;
  logic            full, alloc, pop, rsp_take;
  logic            quiet_q;

  assign head_idx = head_q[ID_W-1:0];
  assign tail_idx = tail_q[ID_W-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[ID_W] != tail_q[ID_W]);

  assign cache_req_valid_o = ld_req_valid_i & ~full;
  assign ld_req_ready_o    = cache_req_ready_i & ~full;
  assign cache_req_addr_o  = ld_req_addr_i;
  assign cache_req_size_o  = ld_req_size_i;
  assign cache_req_tid_o   = tail_idx;
  assign alloc             = cache_req_valid_o & cache_req_ready_i;

  assign rsp_take = cache_rsp_valid_i &&
                    (state_q[cache_rsp_tid_i] == E_PEND || state_q[cache_rsp_tid_i] == E_PEND_K);

  // Killed entries at the head retire without being presented.
  assign pop = (ld_rsp_valid_o & ld_rsp_ready_i) | (state_q[head_idx] == E_DONE_K);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      quiet_q <= 1'b1;
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        state_q[i] <= E_FREE;
        data_q[i]  <= '0;
        err_q[i]   <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        state_q[i] <= state_d[i];
      end
      if (rsp_take) begin
        data_q[cache_rsp_tid_i] <= cache_rsp_data_i;
        err_q[cache_rsp_tid_i]  <= cache_rsp_error_i;
      end
      head_q <= head_q + (ID_W+1)'(pop);
      tail_q <= tail_q + (ID_W+1)'(alloc);
      if (alloc) quiet_q <= 1'b0;
    end
  end

  // Later assignments win: a popped or freshly allocated entry overrides flush/response updates.
  always_comb begin
    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      state_d[i] = state_q[i];
      if (flush_i) begin
        if (state_q[i] == E_PEND) state_d[i] = E_PEND_K;
        if (state_q[i] == E_DONE) state_d[i] = E_DONE_K;
      end
      if (rsp_take && cache_rsp_tid_i == ID_W'(i)) begin
        state_d[i] = (state_q[i] == E_PEND && !flush_i) ? E_DONE : E_DONE_K;
      end
      if (pop && head_idx == ID_W'(i)) state_d[i] = E_FREE;
      if (alloc && tail_idx == ID_W'(i)) state_d[i] = flush_i ? E_PEND_K : E_PEND;
    end
  end

  always_comb begin
    ld_rsp_valid_o = (state_q[head_idx] == E_DONE);
    ld_rsp_data_o  = data_q[head_idx];
    ld_rsp_error_o = err_q[head_idx];
    busy_o         = 1'b0;
    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      if (state_q[i] != E_FREE) busy_o = 1'b1;
    end
  end

  // Stray responses are expected right after reset (loads dropped mid-flight), so the
  // check only arms once a load has been issued since reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !quiet_q && cache_rsp_valid_i) begin
      assert (rsp_take)
        else $error("load tracker: response for tid %0d with no load in flight", cache_rsp_tid_i);
    end
  end

endmodule

// File: tb/tb_cva6_hpdcache_load_tracker.sv
// Bench for cva6_hpdcache_load_tracker: directed scenarios plus a randomized run
// scored against an issue-order queue model of outstanding loads.
module tb_cva6_hpdcache_load_tracker;
  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic          clk_i = 1'b0;
  logic          rst_i, flush_i;
  logic          ld_req_valid_i, ld_req_ready_o;
  logic [AW-1:0] ld_req_addr_i;
  logic [1:0]    ld_req_size_i;
  logic          cache_req_valid_o, cache_req_ready_i;
  logic [AW-1:0] cache_req_addr_o;
  logic [1:0]    cache_req_size_o;
  logic [IW-1:0] cache_req_tid_o;
  logic          cache_rsp_valid_i;
  logic [IW-1:0] cache_rsp_tid_i;
  logic [DW-1:0] cache_rsp_data_i;
  logic          cache_rsp_error_i;
  logic          ld_rsp_valid_o, ld_rsp_ready_i;
  logic [DW-1:0] ld_rsp_data_o;
  logic          ld_rsp_error_o, busy_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [IW-1:0] tid;
    bit            killed;
    bit            resp;
    logic [DW-1:0] data;
    bit            err;
  } ld_t;

  ld_t q[$];

  cva6_hpdcache_load_tracker #(.NR_ENTRIES(N), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .ld_req_valid_i(ld_req_valid_i), .ld_req_ready_o(ld_req_ready_o),
    .ld_req_addr_i(ld_req_addr_i), .ld_req_size_i(ld_req_size_i),
    .cache_req_valid_o(cache_req_valid_o), .cache_req_ready_i(cache_req_ready_i),
    .cache_req_addr_o(cache_req_addr_o), .cache_req_size_o(cache_req_size_o),
    .cache_req_tid_o(cache_req_tid_o),
    .cache_rsp_valid_i(cache_rsp_valid_i), .cache_rsp_tid_i(cache_rsp_tid_i),
    .cache_rsp_data_i(cache_rsp_data_i), .cache_rsp_error_i(cache_rsp_error_i),
    .ld_rsp_valid_o(ld_rsp_valid_o), .ld_rsp_ready_i(ld_rsp_ready_i),
    .ld_rsp_data_o(ld_rsp_data_o), .ld_rsp_error_o(ld_rsp_error_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i = 0; ld_req_valid_i = 0; ld_req_addr_i = '0; ld_req_size_i = '0;
    cache_req_ready_i = 0; cache_rsp_valid_i = 0; cache_rsp_tid_i = '0;
    cache_rsp_data_i = '0; cache_rsp_error_i = 0; ld_rsp_ready_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1;
    tick();
    rst_i = 0;
  endtask

  task automatic rsp(input logic [IW-1:0] tid, input logic [DW-1:0] d, input logic e);
    cache_rsp_valid_i = 1; cache_rsp_tid_i = tid; cache_rsp_data_i = d; cache_rsp_error_i = e;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1; ld_req_valid_i = 1; cache_req_ready_i = 0;
    tick();
    rst_i = 0;
    @(negedge clk_i);
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_o); end
    tests++; if (ld_rsp_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", ld_rsp_valid_o); end
    tests++; if (cache_req_tid_o !== 3'd0) begin fails++; $display("FAIL reset_tid got %0d want 0", cache_req_tid_o); end
    tests++; if (cache_req_valid_o !== 1'b1) begin fails++; $display("FAIL reset_req_valid got %b want 1", cache_req_valid_o); end
    tests++; if (ld_req_ready_o !== 1'b0) begin fails++; $display("FAIL reset_req_ready got %b want 0", ld_req_ready_o); end
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    ld_req_valid_i = 1; ld_req_addr_i = 64'h8000_0010; ld_req_size_i = 2'd3; cache_req_ready_i = 1;
    @(negedge clk_i);
    tests++; if (ld_req_ready_o !== 1'b1) begin fails++; $display("FAIL single_ready got %b want 1", ld_req_ready_o); end
    tests++; if (cache_req_tid_o !== 3'd0) begin fails++; $display("FAIL single_tid got %0d want 0", cache_req_tid_o); end
    tests++; if (cache_req_addr_o !== 64'h8000_0010) begin fails++; $display("FAIL single_addr got %h want 80000010", cache_req_addr_o); end
    tests++; if (cache_req_size_o !== 2'd3) begin fails++; $display("FAIL single_size got %0d want 3", cache_req_size_o); end
    tick();
    ld_req_valid_i = 0; ld_rsp_ready_i = 1;
    rsp(3'd0, 64'hDEAD, 1'b0);
    @(negedge clk_i);
    tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL single_busy got %b want 1", busy_o); end
    tests++; if (ld_rsp_valid_o !== 1'b0) begin fails++; $display("FAIL single_nobypass got %b want 0", ld_rsp_valid_o); end
    tick();
    cache_rsp_valid_i = 0;
    @(negedge clk_i);
    tests++; if (ld_rsp_valid_o !== 1'b1 || ld_rsp_data_o !== 64'hDEAD)
      begin fails++; $display("FAIL single_data got v=%b d=%h want v=1 d=dead", ld_rsp_valid_o, ld_rsp_data_o); end
    tick();
    @(negedge clk_i);
    tests++; if (busy_o !== 1'b0 || ld_rsp_valid_o !== 1'b0)
      begin fails++; $display("FAIL single_drain got busy=%b v=%b want 0 0", busy_o, ld_rsp_valid_o); end
    idle_inputs();
  endtask

  task automatic test_out_of_order();
    do_reset();
    ld_rsp_ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      ld_req_valid_i = 1; ld_req_addr_i = 64'(i * 8); cache_req_ready_i = 1;
      @(negedge clk_i);
      tests++; if (cache_req_tid_o !== 3'(i)) begin fails++; $display("FAIL ooo_tid got %0d want %0d", cache_req_tid_o, i); end
      tick();
    end
    ld_req_valid_i = 0;
    rsp(3'd2, 64'hA2, 1'b0);
    @(negedge clk_i);
    tests++; if (ld_rsp_valid_o !== 1'b0) begin fails++; $display("FAIL ooo_hold2 got %b want 0", ld_rsp_valid_o); end
    tick(); rsp(3'd0, 64'hA0, 1'b0);
    @(negedge clk_i);
    tests++; if (ld_rsp_valid_o !== 1'b0) begin fails++; $display("FAIL ooo_lat0 got %b want 0", ld_rsp_valid_o); end
    tick(); cache_rsp_valid_i = 0;
    @(negedge clk_i);
    tests++; if (ld_rsp_valid_o !== 1'b1 || ld_rsp_data_o !== 64'hA0)
      begin fails++; $display("FAIL ooo_d0 got v=%b d=%h want v=1 d=a0", ld_rsp_valid_o, ld_rsp_data_o); end
    tick(); rsp(3'd1, 64'hA1, 1'b0);
    @(negedge clk_i);
    tests++; if (ld_rsp_valid_o !== 1'b0) begin fails++; $display("FAIL ooo_wait1 got %b want 0", ld_rsp_valid_o); end
    tick(); cache_rsp_valid_i = 0;
    @(negedge clk_i);
    tests++; if (ld_rsp_valid_o !== 1'b1 || ld_rsp_data_o !== 64'hA1)
      begin fails++; $display("FAIL ooo_d1 got v=%b d=%h want v=1 d=a1", ld_rsp_valid_o, ld_rsp_data_o); end
    tick();
    @(negedge clk_i);
    tests++; if (ld_rsp_valid_o !== 1'b1 || ld_rsp_data_o !== 64'hA2)
      begin fails++; $display("FAIL ooo_d2 got v=%b d=%h want v=1 d=a2", ld_rsp_valid_o, ld_rsp_data_o); end
    tick();
    @(negedge clk_i);
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL ooo_idle got %b want 0", busy_o); end
    idle_inputs();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ld_req_valid_i = 1; ld_req_addr_i = 64'(i); cache_req_ready_i = 1;
      @(negedge clk_i);
      tests++; if (ld_req_ready_o !== 1'b1 || cache_req_tid_o !== 3'(i))
        begin fails++; $display("FAIL full_fill got rdy=%b tid=%0d want rdy=1 tid=%0d", ld_req_ready_o, cache_req_tid_o, i); end
      tick();
    end
    rsp(3'd0, 64'h90, 1'b0);
    @(negedge clk_i);
    tests++; if (ld_req_ready_o !== 1'b0 || cache_req_valid_o !== 1'b0)
      begin fails++; $display("FAIL full_9th got rdy=%b v=%b want 0 0", ld_req_ready_o, cache_req_valid_o); end
    tick(); cache_rsp_valid_i = 0; ld_rsp_ready_i = 1;
    @(negedge clk_i);
    tests++; if (ld_rsp_valid_o !== 1'b1 || ld_rsp_data_o !== 64'h90)
      begin fails++; $display("FAIL full_pop got v=%b d=%h want v=1 d=90", ld_rsp_valid_o, ld_rsp_data_o); end
    tests++; if (ld_req_ready_o !== 1'b0) begin fails++; $display("FAIL full_nobypass got %b want 0", ld_req_ready_o); end
    tick(); ld_rsp_ready_i = 0;
    @(negedge clk_i);
    tests++; if (ld_req_ready_o !== 1'b1 || cache_req_valid_o !== 1'b1 || cache_req_tid_o !== 3'd0)
      begin fails++; $display("FAIL full_wrap got rdy=%b v=%b tid=%0d want 1 1 0", ld_req_ready_o, cache_req_valid_o, cache_req_tid_o); end
    tick();
    @(negedge clk_i);
    tests++; if (ld_req_ready_o !== 1'b0) begin fails++; $display("FAIL full_again got %b want 0", ld_req_ready_o); end
    idle_inputs();
  endtask

  task automatic test_flush();
    int cnt;
    bit early;
    do_reset();
    ld_rsp_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      ld_req_valid_i = 1; cache_req_ready_i = 1;
      @(negedge clk_i);
      tests++; if (cache_req_tid_o !== 3'(i)) begin fails++; $display("FAIL flush_tid got %0d want %0d", cache_req_tid_o, i); end
      tick();
    end
    ld_req_valid_i = 0;
    rsp(3'd1, 64'h11, 1'b0);
    tick(); cache_rsp_valid_i = 0; flush_i = 1;
    tick(); flush_i = 0; ld_req_valid_i = 1;
    @(negedge clk_i);
    tests++; if (cache_req_tid_o !== 3'd4) begin fails++; $display("FAIL flush_newtid got %0d want 4", cache_req_tid_o); end
    tick(); ld_req_valid_i = 0;
    rsp(3'd4, 64'hF00D, 1'b0);
    early = 0;
    @(negedge clk_i); if (ld_rsp_valid_o) early = 1;
    for (int k = 0; k < 3; k++) begin
      tick(); rsp((k == 0) ? 3'd0 : 3'(k + 1), 64'hBAD, 1'b0);
      @(negedge clk_i); if (ld_rsp_valid_o) early = 1;
    end
    tests++; if (early) begin fails++; $display("FAIL flush_killed_seen got valid=1 want no valid before rsp 0,2,3"); end
    tick(); cache_rsp_valid_i = 0;
    cnt = 0;
    @(negedge clk_i);
    while (!ld_rsp_valid_o && cnt < 20) begin tick(); @(negedge clk_i); cnt++; end
    tests++; if (ld_rsp_valid_o !== 1'b1 || ld_rsp_data_o !== 64'hF00D)
      begin fails++; $display("FAIL flush_new_data got v=%b d=%h want v=1 d=f00d", ld_rsp_valid_o, ld_rsp_data_o); end
    tick();
    @(negedge clk_i);
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL flush_idle got %b want 0", busy_o); end
    idle_inputs();
  endtask

  task automatic test_stall_error();
    do_reset();
    ld_req_valid_i = 1; cache_req_ready_i = 1;
    tick(); ld_req_valid_i = 0;
    rsp(3'd0, 64'h1234, 1'b1);
    tick(); cache_rsp_valid_i = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      tests++; if (ld_rsp_valid_o !== 1'b1 || ld_rsp_data_o !== 64'h1234 || ld_rsp_error_o !== 1'b1)
        begin fails++; $display("FAIL stall_hold got v=%b d=%h e=%b want 1 1234 1", ld_rsp_valid_o, ld_rsp_data_o, ld_rsp_error_o); end
      tick();
    end
    ld_rsp_ready_i = 1;
    tick(); ld_rsp_ready_i = 0;
    @(negedge clk_i);
    tests++; if (ld_rsp_valid_o !== 1'b0 || busy_o !== 1'b0)
      begin fails++; $display("FAIL stall_pop got v=%b busy=%b want 0 0", ld_rsp_valid_o, busy_o); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ld_req_valid_i = 1; cache_req_ready_i = 1;
      tick();
    end
    ld_req_valid_i = 0; rst_i = 1;
    @(negedge clk_i);
    tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL rstmid_pre got %b want 1", busy_o); end
    tick(); rst_i = 0;
    @(negedge clk_i);
    tests++; if (busy_o !== 1'b0 || cache_req_tid_o !== 3'd0)
      begin fails++; $display("FAIL rstmid_post got busy=%b tid=%0d want 0 0", busy_o, cache_req_tid_o); end
    tick(); rsp(3'd1, 64'h77, 1'b0);
    tick(); cache_rsp_valid_i = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      tests++; if (ld_rsp_valid_o !== 1'b0 || busy_o !== 1'b0)
        begin fails++; $display("FAIL rstmid_late got v=%b busy=%b want 0 0", ld_rsp_valid_o, busy_o); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int unsigned alloc_cnt;
    int          pend[$];
    int          j;
    bit          ok, drained, do_rsp;
    logic [IW-1:0] rtid;
    logic [DW-1:0] rdata;
    bit          rerr;
    do_reset();
    q.delete();
    alloc_cnt = 0;
    drained = 0;
    for (int c = 0; c < 3400; c++) begin
      tick();
      if (c >= 3000) begin
        ok = (busy_o == 1'b0);
        foreach (q[k]) if (!(q[k].killed && q[k].resp)) ok = 0;
        if (ok) begin drained = 1; break; end
      end
      pend.delete();
      foreach (q[k]) if (!q[k].resp) pend.push_back(k);
      if (c < 3000) begin
        flush_i = ($urandom_range(0, 15) == 0);
        ld_req_valid_i = 1'($urandom_range(0, 1));
        cache_req_ready_i = ($urandom_range(0, 3) != 0);
        ld_rsp_ready_i = ($urandom_range(0, 3) != 0);
        do_rsp = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
      end else begin
        flush_i = 0; ld_req_valid_i = 0; cache_req_ready_i = 1; ld_rsp_ready_i = 1;
        do_rsp = (pend.size() > 0);
      end
      ld_req_addr_i = {$urandom(), $urandom()};
      ld_req_size_i = 2'($urandom_range(0, 3));
      rtid = '0; rdata = '0; rerr = 0;
      if (do_rsp) begin
        rtid = q[pend[$urandom_range(0, pend.size() - 1)]].tid;
        rdata = {$urandom(), $urandom()};
        rerr = ($urandom_range(0, 7) == 0);
        rsp(rtid, rdata, rerr);
      end else begin
        cache_rsp_valid_i = 0;
      end
      @(negedge clk_i);
      if (ld_rsp_valid_o) begin
        j = -1;
        ok = 1;
        foreach (q[k]) if (j < 0) begin
          if (!q[k].killed) j = k;
          else if (!q[k].resp) ok = 0;
        end
        tests++;
        if (j < 0 || !ok || !q[j].resp) begin
          fails++; $display("FAIL rnd_valid_early cycle %0d got valid=1 want no deliverable load", c);
        end else begin
          tests++;
          if (ld_rsp_data_o !== q[j].data || ld_rsp_error_o !== q[j].err) begin
            fails++; $display("FAIL rnd_data cycle %0d got d=%h e=%b want d=%h e=%b",
                              c, ld_rsp_data_o, ld_rsp_error_o, q[j].data, q[j].err);
          end
          if (ld_rsp_ready_i) for (int k = 0; k <= j; k++) void'(q.pop_front());
        end
      end
      if (flush_i) foreach (q[k]) q[k].killed = 1;
      if (do_rsp) foreach (q[k]) if (q[k].tid == rtid && !q[k].resp) begin
        q[k].resp = 1; q[k].data = rdata; q[k].err = rerr;
      end
      if (cache_req_valid_o && cache_req_ready_i) begin
        tests++;
        if (cache_req_tid_o !== IW'(alloc_cnt % N) || cache_req_addr_o !== ld_req_addr_i) begin
          fails++; $display("FAIL rnd_alloc cycle %0d got tid=%0d addr=%h want tid=%0d addr=%h",
                            c, cache_req_tid_o, cache_req_addr_o, alloc_cnt % N, ld_req_addr_i);
        end
        q.push_back('{tid: cache_req_tid_o, killed: flush_i, resp: 0, data: '0, err: 0});
        alloc_cnt++;
      end
    end
    tests++;
    if (!drained) begin fails++; $display("FAIL rnd_drain got busy=%b outstanding=%0d want idle", busy_o, q.size()); end
    idle_inputs();
  endtask

  initial begin
    rst_i = 1;
    idle_inputs();
    test_reset();
    test_single();
    test_out_of_order();
    test_full();
    test_flush();
    test_stall_error();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
